// File: rtl/clkdiv_multi.sv
// Multi-channel programmable clock divider for the audio clock tree.
// Each channel toggles its output every H+1 enabled cycles and reports edges as strobes.
module clkdiv_multi #(
   parameter int NUM_CH       = 3,
   parameter int CNT_W        = 16,
   parameter int DEFAULT_HALF = 2,
   parameter int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              sync,
   input  logic              cfg_we,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_half,
   output logic [NUM_CH-1:0] cfg_pend,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] rise,
   output logic [NUM_CH-1:0] fall
);

   localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(DEFAULT_HALF);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      localparam logic [CH_W-1:0] CH_ID = CH_W'(i);

      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] half;
      logic [CNT_W-1:0] pend_val;
      logic             pend;
      logic             out;
      logic             rise_q;
      logic             fall_q;
      logic             wr;
      logic             term;

      // Out-of-range channel numbers never match any CH_ID, so those writes fall away.
      assign wr   = cfg_we && (cfg_ch == CH_ID);
      assign term = en && (cnt == half);

      // NOTE: reset is sampled synchronously and all state uses non-blocking
      // assignments so every channel updates from the same pre-edge values.
      always_ff @(posedge clk) begin
         if (rst) begin
            cnt      <= '0;
            half     <= HALF_RST;
            pend_val <= '0;
            pend     <= 1'b0;
            out      <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
         end else if (sync) begin
            cnt    <= '0;
            out    <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= out;
            if (wr) begin
               half <= cfg_half;
               pend <= 1'b0;
            end else if (pend) begin
               half <= pend_val;
               pend <= 1'b0;
            end
         end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (term) begin
               cnt    <= '0;
               out    <= ~out;
               rise_q <= ~out;
               fall_q <= out;
            end else if (en) begin
               cnt <= cnt + CNT_W'(1);
            end
            // Half-period only changes while cnt restarts at zero, so no runt pulses.
            if (term && wr) begin
               half <= cfg_half;
               pend <= 1'b0;
            end else if (term && pend) begin
               half <= pend_val;
               pend <= 1'b0;
            end else if (wr) begin
               pend_val <= cfg_half;
               pend     <= 1'b1;
            end
         end
      end

      assign cfg_pend[i] = pend;
      assign clk_out[i]  = out;
      assign rise[i]     = rise_q;
      assign fall[i]     = fall_q;
   end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Self-checking bench for clkdiv_multi: directed scenarios plus random traffic
// compared every cycle against a per-channel elapsed-time model.
module tb_clkdiv_multi;

   localparam int NUM_CH       = 3;
   localparam int CNT_W        = 16;
   localparam int DEFAULT_HALF = 2;
   localparam int CH_W         = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              en = 1'b0;
   logic              sync = 1'b0;
   logic              cfg_we = 1'b0;
   logic [CH_W-1:0]   cfg_ch = '0;
   logic [CNT_W-1:0]  cfg_half = '0;
   logic [NUM_CH-1:0] cfg_pend;
   logic [NUM_CH-1:0] clk_out;
   logic [NUM_CH-1:0] rise;
   logic [NUM_CH-1:0] fall;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   // Model: cycles elapsed in the current half-period, active H, pending H.
   int                m_age [NUM_CH];
   int                m_h   [NUM_CH];
   int                m_pv  [NUM_CH];
   logic [NUM_CH-1:0] exp_out  = '0;
   logic [NUM_CH-1:0] exp_rise = '0;
   logic [NUM_CH-1:0] exp_fall = '0;
   logic [NUM_CH-1:0] exp_pend = '0;

   always #5 clk = ~clk;

   clkdiv_multi #(
      .NUM_CH       (NUM_CH),
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (DEFAULT_HALF),
      .CH_W         (CH_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .sync     (sync),
      .cfg_we   (cfg_we),
      .cfg_ch   (cfg_ch),
      .cfg_half (cfg_half),
      .cfg_pend (cfg_pend),
      .clk_out  (clk_out),
      .rise     (rise),
      .fall     (fall)
   );

   task automatic check(input string tag, input logic [NUM_CH-1:0] got, input logic [NUM_CH-1:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s cyc=%0d: got %b expected %b", tag, cyc, got, exp);
      end
   endtask

   task automatic check_int(input string tag, input int got, input int exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s cyc=%0d: got %0d expected %0d", tag, cyc, got, exp);
      end
   endtask

   task automatic model_step();
      for (int i = 0; i < NUM_CH; i++) begin
         bit wr;
         bit term;
         wr = cfg_we && (int'(cfg_ch) == i);
         if (rst) begin
            m_age[i] = 0; m_h[i] = DEFAULT_HALF; m_pv[i] = 0;
            exp_pend[i] = 1'b0; exp_out[i] = 1'b0; exp_rise[i] = 1'b0; exp_fall[i] = 1'b0;
         end else if (sync) begin
            exp_fall[i] = exp_out[i];
            exp_rise[i] = 1'b0;
            exp_out[i]  = 1'b0;
            m_age[i]    = 0;
            if (wr) begin
               m_h[i] = int'(cfg_half); exp_pend[i] = 1'b0;
            end else if (exp_pend[i]) begin
               m_h[i] = m_pv[i]; exp_pend[i] = 1'b0;
            end
         end else begin
            term = en && (m_age[i] == m_h[i]);
            exp_rise[i] = 1'b0;
            exp_fall[i] = 1'b0;
            if (term) begin
               m_age[i]    = 0;
               exp_out[i]  = ~exp_out[i];
               exp_rise[i] = exp_out[i];
               exp_fall[i] = ~exp_out[i];
               if (wr) begin
                  m_h[i] = int'(cfg_half); exp_pend[i] = 1'b0;
               end else if (exp_pend[i]) begin
                  m_h[i] = m_pv[i]; exp_pend[i] = 1'b0;
               end
            end else begin
               if (en) m_age[i]++;
               if (wr) begin
                  m_pv[i] = int'(cfg_half); exp_pend[i] = 1'b1;
               end
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      cyc++;
      #1;
      check("clk_out", clk_out, exp_out);
      check("rise", rise, exp_rise);
      check("fall", fall, exp_fall);
      check("cfg_pend", cfg_pend, exp_pend);
   endtask

   task automatic wait_edge(input int ch, input bit want_rise, input int limit, output int n);
      bit seen;
      seen = 1'b0;
      n = 0;
      while (!seen && n < limit) begin
         tick();
         n++;
         seen = want_rise ? rise[ch] : fall[ch];
      end
      check_int(want_rise ? "rise_timeout" : "fall_timeout", int'(seen), 1);
   endtask

   task automatic write_cfg(input int ch, input int h);
      cfg_we   = 1'b1;
      cfg_ch   = CH_W'(ch);
      cfg_half = CNT_W'(h);
      tick();
      cfg_we   = 1'b0;
   endtask

   initial begin
      int n;
      int first [NUM_CH];

      // Reset state
      tick();
      tick();
      check("reset_out", clk_out, 3'b000);
      check("reset_pend", cfg_pend, 3'b000);

      // Defaults: H=2, first rise after edge 3, period 6 at 50% duty
      rst = 1'b0;
      en  = 1'b1;
      tick();
      tick();
      tick();
      check("first_rise", rise, 3'b111);
      check("first_level", clk_out, 3'b111);
      wait_edge(0, 1'b0, 10, n);
      check_int("default_high_len", n, 3);
      wait_edge(0, 1'b1, 10, n);
      check_int("default_low_len", n, 3);
      repeat (1000) tick();

      // Two writes before a terminal: only the later value applies
      wait_edge(1, 1'b1, 20, n);
      write_cfg(1, 0);
      cfg_we = 1'b1; cfg_ch = 2'd1; cfg_half = 16'd5;
      tick();
      cfg_we = 1'b0;
      check_int("ch1_pend_held", int'(cfg_pend[1]), 1);
      wait_edge(1, 1'b0, 5, n);
      check_int("ch1_apply_at_terminal", n, 1);
      check_int("ch1_pend_cleared", int'(cfg_pend[1]), 0);
      wait_edge(1, 1'b1, 20, n);
      check_int("ch1_new_half_len", n, 6);

      // Write landing on ch0's terminal applies directly
      wait_edge(0, 1'b1, 20, n);
      tick();
      tick();
      write_cfg(0, 7);
      check_int("ch0_terminal_fall", int'(fall[0]), 1);
      check_int("ch0_no_pend", int'(cfg_pend[0]), 0);
      wait_edge(0, 1'b1, 20, n);
      check_int("ch0_direct_half_len", n, 8);

      // Mixed half-periods, then sync aligns every channel
      write_cfg(0, 1);
      write_cfg(1, 3);
      write_cfg(2, 767);
      repeat (2000) tick();
      sync = 1'b1;
      tick();
      sync = 1'b0;
      check("sync_clears_out", clk_out, 3'b000);
      for (int i = 0; i < NUM_CH; i++) first[i] = -1;
      for (int k = 1; k <= 800; k++) begin
         tick();
         for (int i = 0; i < NUM_CH; i++)
            if (rise[i] && first[i] < 0) first[i] = k;
      end
      check_int("sync_rise_ch0", first[0], 2);
      check_int("sync_rise_ch1", first[1], 4);
      check_int("sync_rise_ch2", first[2], 768);

      // Enable held low for 10 cycles stretches the half-period by 10
      wait_edge(1, 1'b1, 20, n);
      tick();
      en = 1'b0;
      repeat (10) tick();
      check_int("en_hold_level", int'(clk_out[1]), 1);
      en = 1'b1;
      wait_edge(1, 1'b0, 30, n);
      check_int("en_stretched_len", 1 + 10 + n, 3 + 1 + 10);

      // Out-of-range channel ignored; reset discards a pending write
      write_cfg(3, 9);
      check("bad_ch_ignored", cfg_pend, 3'b000);
      write_cfg(2, 9);
      check("ch2_pending", cfg_pend, 3'b100);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_clears_pend", cfg_pend, 3'b000);
      wait_edge(2, 1'b1, 10, n);
      check_int("rst_restores_half", n, 3);

      // Random traffic against the model
      for (int k = 0; k < 3000; k++) begin
         en       = ($urandom_range(0, 9) != 0);
         sync     = ($urandom_range(0, 99) == 0);
         rst      = ($urandom_range(0, 499) == 0);
         cfg_we   = ($urandom_range(0, 3) == 0);
         cfg_ch   = CH_W'($urandom_range(0, 3));
         cfg_half = CNT_W'($urandom_range(0, 9));
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/clkdiv_multi.md
# clkdiv_multi

Parametrised multi-channel clock divider for the synthesiser's audio clock tree: it generates NUM_CH independent divided clocks (MCLK, BCLK, LRCK and similar) from the 100 MHz system clock. It extends the fixed two-channel divider with runtime-programmable half-periods, glitch-free reconfiguration, a global enable, and a phase-alignment restart. Per-channel edge strobes let downstream serialisers act on divided-clock edges without sampling the divided clocks.

## Interface
Parameters:
- NUM_CH, 3: number of divider channels (≥1).
- CNT_W, 16: counter and half-period register width.
- DEFAULT_HALF, 2: reset half-period value loaded into every channel.
- CH_W, max(1, clog2(NUM_CH)): channel-select width (derived).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous active-high reset.
- en  in  1  global count enable; counters hold when low.
- sync  in  1  one-cycle restart pulse; phase-aligns all channels.
- cfg_we  in  1  half-period write strobe.
- cfg_ch  in  CH_W  channel addressed by cfg_we.
- cfg_half  in  CNT_W  new half-period value H.
- cfg_pend  out  NUM_CH  per channel, high while a written value awaits application.
- clk_out  out  NUM_CH  divided clocks.
- rise  out  NUM_CH  one-cycle strobe, high in the cycle clk_out[i] is newly 1.
- fall  out  NUM_CH  one-cycle strobe, high in the cycle clk_out[i] is newly 0.

## Operation
- Per-channel state: cnt[CNT_W], half[CNT_W], pend_val[CNT_W], pend flag, out bit. All outputs are registered.
- Reset: cnt=0, half=DEFAULT_HALF, pend=0, pend_val=0, clk_out=0, rise=0, fall=0. Reset has priority over all other inputs.
- Count: when en=1 and cnt<half, cnt←cnt+1. When en=1 and cnt==half (terminal), cnt←0 and out toggles.
  - Half-period is H+1 cycles; output period is 2(H+1). H=0 gives divide-by-2.
  - cnt never exceeds half, so there is no wrap or overflow. The maximum H is 2^CNT_W−1.
- Config write (cfg_we=1, cfg_ch<NUM_CH): pend_val←cfg_half and pend←1. A later write before application overwrites pend_val.
  - Writes with cfg_ch≥NUM_CH are ignored.
- Application: at a terminal cycle with pend=1, half←pend_val and pend←0. The new H governs the next half-period. Because half only changes when cnt=0, there are no runt pulses.
- Same-cycle write and terminal on the same channel: cfg_half is applied directly (half←cfg_half). pend←0, and any older pending value is discarded.
- en=0: cnt and out hold; pending values stay pending; cfg writes are still accepted.
- sync=1, priority over en and count:
  - Every channel: cnt←0, out←0.
  - A pending value is applied immediately and pend←0.
  - A same-cycle cfg write to a channel applies cfg_half to that channel immediately.
- Strobes: rise[i]=1 only in the cycle after an edge that took out 0→1. fall[i]=1 only in the cycle after an edge that took out 1→0, including a sync forcing 1→0. Both are 0 otherwise.

## Timing
- Latency: clk_out, rise and fall change on the same clock edge that detects the terminal. Strobe and level are coincident.
- From reset release with en=1 held and H=2: cnt=1, 2 after edges 1 and 2; clk_out=1 and rise=1 after edge 3. clk_out=0 and fall=1 after edge 6.
- cfg_pend rises the edge after cfg_we. It falls on the edge that applies the value.
- After sync, all channels with equal H produce their first rising edge on the same cycle: H+1 enabled edges after the sync edge.
- rst mid-operation: all state returns to reset values on that edge; pending writes are lost.

## Test plan
- Reset, en=1, defaults (H=2): each clk_out has period 6 cycles at 50% duty. rise/fall are single-cycle and coincident with the level change; 1000 cycles show no strobe while the level is unchanged.
- Write ch1 H=0 mid half-period, then H=5 before the terminal: cfg_pend[1] is high until the terminal. Only H=5 is applied, and the next half-period is exactly 6 cycles with no runt.
- Write aimed to land on the terminal cycle of ch0 with H=7: applied immediately, the next half-period is 8 cycles, and cfg_pend[0] stays 0.
- Channels at H=1, 3, 767, free-running, then sync pulse: all clk_out go 0 and falls pulse where out was 1. Rises at 2, 4, 768 cycles after sync are all aligned to the sync edge.
- en low for 10 cycles mid-count: cnt and clk_out frozen. Resuming completes the half-period with the remaining count; total length is H+1+10.
- cfg_ch=3 with NUM_CH=3 is ignored. rst asserted with a pending write clears cfg_pend, and half returns to DEFAULT_HALF.
